// File: rtl/seg7_num_display.sv
// ---------------------------------------------------------------------------
// seg7_num_display
//
// Converts CHANNELS two's-complement values into active-low seven-segment
// patterns, one channel after another, and presents all channels at once.
//
//   mode = 0 : hexadecimal, the low DIGITS nibbles of the raw value, dp off
//   mode = 1 : signed decimal through a serial double-dabble converter.
//              A negative value lights the dp of the most significant digit.
//              A magnitude that needs more than DIGITS decimal digits shows
//              a dash (g segment only) on every digit of that channel.
//
// Per-channel sequence: ABS (1 cycle), SHIFT (WIDTH cycles), COMMIT (1 cycle).
// After the last channel, DONE copies the pending buffer to seg and the
// done pulse appears with the segments.
//
// Build option:
//   SEG7_LZB_EN  when defined, decimal results blank leading zero digits
//                above digit 0. Hex and overflow patterns are unaffected.
//                When undefined, every digit is shown, including leading
//                zeros.
// ---------------------------------------------------------------------------
module seg7_num_display #(
    parameter int WIDTH    = 9,
    parameter int DIGITS   = 3,
    parameter int CHANNELS = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         load,
    input  logic                         mode,
    input  logic [CHANNELS*WIDTH-1:0]    value,
    output logic                         busy,
    output logic                         done,
    output logic [CHANNELS*DIGITS*8-1:0] seg
);

    // A WIDTH-bit magnitude needs at most ceil(WIDTH/3) decimal digits.
    // The BCD register must also hold DIGITS nibbles for hex display and
    // must be at least WIDTH bits wide, so raw hex bits are never lost.
    localparam int DEC_NIB  = (WIDTH + 2) / 3;
    localparam int NIB      = (DEC_NIB > DIGITS) ? DEC_NIB : DIGITS;
    localparam int BCD_W    = 4 * NIB;
    localparam int CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CH_SEG_W = DIGITS * 8;
    localparam int SEG_W    = CHANNELS * CH_SEG_W;

    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);
    localparam logic [CH_W-1:0]  LAST_CHAN  = CH_W'(CHANNELS - 1);

    // Glyphs with the dp segment set to off.
    localparam logic [7:0] GLYPH_DASH  = 8'hBF;
    localparam logic [7:0] GLYPH_BLANK = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        ABS,
        SHIFT,
        COMMIT,
        DONE
    } state_t;

    state_t                    state;
    logic [CHANNELS*WIDTH-1:0] value_q;    // shadow copy of all channel values
    logic                      mode_q;     // 1 = signed decimal
    logic [CH_W-1:0]           chan;       // channel being converted
    logic [CNT_W-1:0]          cnt;        // shift step within SHIFT
    logic                      sign_q;     // channel value is negative (decimal only)
    logic [WIDTH-1:0]          sh_q;       // magnitude bits still to be shifted in
    logic [BCD_W-1:0]          bcd_q;      // BCD digits (decimal) or raw bits (hex)
    logic [SEG_W-1:0]          pending;    // segments committed, not yet displayed

    logic [WIDTH-1:0]          raw;
    logic [WIDTH-1:0]          mag;
    logic [BCD_W-1:0]          bcd_adj;
    logic [BCD_W-1:0]          bcd_src;
    logic [BCD_W+WIDTH-1:0]    shifted;
    logic                      ovf;
    logic [3:0]                nib;
    logic [7:0]                glyph;
    logic [CH_SEG_W-1:0]       ch_seg;
`ifdef SEG7_LZB_EN
    logic                      lead;
`endif

    // Active-low seven-segment glyph for one nibble, dp off.
    function automatic logic [7:0] glyph_of(input logic [3:0] n);
        logic [7:0] g;
        case (n)
            4'h0:    g = 8'hC0;
            4'h1:    g = 8'hF9;
            4'h2:    g = 8'hA4;
            4'h3:    g = 8'hB0;
            4'h4:    g = 8'h99;
            4'h5:    g = 8'h92;
            4'h6:    g = 8'h82;
            4'h7:    g = 8'hF8;
            4'h8:    g = 8'h80;
            4'h9:    g = 8'h90;
            4'hA:    g = 8'h88;
            4'hB:    g = 8'h83;
            4'hC:    g = 8'hC6;
            4'hD:    g = 8'hA1;
            4'hE:    g = 8'h86;
            default: g = 8'h8E;
        endcase
        return g;
    endfunction

    // Select the current channel and form its magnitude; the most negative
    // value negates to itself, which read as unsigned is exactly 2^(WIDTH-1).
    always_comb begin
        raw = value_q[int'(chan)*WIDTH +: WIDTH];
        mag = raw;
        if (mode_q && raw[WIDTH-1]) begin
            mag = -raw;
        end
    end

    // One double-dabble step: add 3 to every nibble >= 5, then shift left.
    // Hex mode skips the correction so the raw bits pass through unchanged.
    always_comb begin
        // NOTE: every variable written here gets a value before any branch,
        // so no path leaves it holding an old value (which would infer a latch).
        bcd_adj = bcd_q;
        for (int i = 0; i < NIB; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_src = mode_q ? bcd_adj : bcd_q;
        shifted = {bcd_src, sh_q} << 1;
    end

    // Encode the finished channel: glyphs, decimal overflow dash, leading
    // zero blanking (optional) and the sign dp on the top digit.
    always_comb begin
        ovf    = 1'b0;
        nib    = 4'h0;
        glyph  = GLYPH_BLANK;
        ch_seg = '1;
`ifdef SEG7_LZB_EN
        lead   = 1'b1;
`endif
        for (int i = DIGITS; i < NIB; i++) begin
            ovf = ovf | (|bcd_q[4*i +: 4]);
        end
        for (int d = DIGITS - 1; d >= 0; d--) begin
            nib   = bcd_q[4*d +: 4];
            glyph = glyph_of(nib);
            if (mode_q) begin
                if (ovf) begin
                    glyph = GLYPH_DASH;
                end
`ifdef SEG7_LZB_EN
                else if (lead && (nib == 4'h0) && (d != 0)) begin
                    glyph = GLYPH_BLANK;
                end
                if (nib != 4'h0) begin
                    lead = 1'b0;
                end
`endif
                if (sign_q && (d == DIGITS - 1)) begin
                    glyph[7] = 1'b0;
                end
            end
            ch_seg[d*8 +: 8] = glyph;
        end
    end

    // Conversion FSM with its datapath and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            // NOTE: seg and pending are ordinary flops rather than a RAM, so
            // they can and must be reset; blank is the only safe power-up image.
            seg     <= '1;
            pending <= '1;
            value_q <= '0;
            mode_q  <= 1'b0;
            chan    <= '0;
            cnt     <= '0;
            sign_q  <= 1'b0;
            sh_q    <= '0;
            bcd_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // samples the values from before this edge regardless of order.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        value_q <= value;
                        mode_q  <= mode;
                        chan    <= '0;
                        busy    <= 1'b1;
                        state   <= ABS;
                    end
                end
                ABS: begin
                    sign_q <= mode_q & raw[WIDTH-1];
                    sh_q   <= mag;
                    bcd_q  <= '0;
                    cnt    <= '0;
                    state  <= SHIFT;
                end
                SHIFT: begin
                    {bcd_q, sh_q} <= shifted;
                    if (cnt == LAST_SHIFT) begin
                        state <= COMMIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                COMMIT: begin
                    pending[int'(chan)*CH_SEG_W +: CH_SEG_W] <= ch_seg;
                    if (chan == LAST_CHAN) begin
                        state <= DONE;
                    end else begin
                        chan  <= chan + 1'b1;
                        state <= ABS;
                    end
                end
                DONE: begin
                    seg   <= pending;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_num_display.sv
// ---------------------------------------------------------------------------
// tb_seg7_num_display
//
// Two instances: the default build (WIDTH=9) and a WIDTH=11 build that can
// exceed three decimal digits. Expected segment images are literal constants
// worked out by hand from the glyph table; the leading-zero choice follows
// SEG7_LZB_EN, exactly as the design does.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seg7_num_display;

`ifdef SEG7_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    localparam logic [47:0] BLANK = '1;
    localparam int          LAT_A = 23;   // 2*(9+2)+1
    localparam int          LAT_B = 27;   // 2*(11+2)+1

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load_a, mode_a, busy_a, done_a;
    logic [17:0] value_a;
    logic [47:0] seg_a;
    logic        load_b, mode_b, busy_b, done_b;
    logic [21:0] value_b;
    logic [47:0] seg_b;

    int checks   = 0;
    int failures = 0;

    logic [47:0] q_a[$];
    logic [47:0] q_b[$];

    typedef struct {
        string       name;
        bit          sel;    // 0 = WIDTH 9 instance, 1 = WIDTH 11 instance
        bit          mode;
        int          v0;
        int          v1;
        logic [47:0] exp;    // {ch1 d2,d1,d0, ch0 d2,d1,d0}
    } vec_t;

    vec_t vecs[14];

    always #5 clk = ~clk;

    seg7_num_display #(.WIDTH(9), .DIGITS(3), .CHANNELS(2)) u_a (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load_a),
        .mode    (mode_a),
        .value   (value_a),
        .busy    (busy_a),
        .done    (done_a),
        .seg     (seg_a)
    );

    seg7_num_display #(.WIDTH(11), .DIGITS(3), .CHANNELS(2)) u_b (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load_b),
        .mode    (mode_b),
        .value   (value_b),
        .busy    (busy_b),
        .done    (done_b),
        .seg     (seg_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input bit s, input bit m,
                                input int a, input int b, input logic [47:0] e);
        vec_t t;
        t.name = n;
        t.sel  = s;
        t.mode = m;
        t.v0   = a;
        t.v1   = b;
        t.exp  = e;
        return t;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done_a) begin
            if (q_a.size() == 0) check("spurious_done_a", 1, 0);
            else                 check("seg_a", seg_a, q_a.pop_front());
        end
        if (done_b) begin
            if (q_b.size() == 0) check("spurious_done_b", 1, 0);
            else                 check("seg_b", seg_b, q_b.pop_front());
        end
    end

    // Apply one vector, check busy, latency and that seg holds until done.
    task automatic run_vec(input vec_t t);
        logic [47:0] prev;
        bit          seen;
        bit          held;
        int          lat;
        lat = t.sel ? LAT_B : LAT_A;
        @(negedge clk);
        if (!t.sel) begin
            value_a = {9'(t.v1), 9'(t.v0)};
            mode_a  = t.mode;
            load_a  = 1'b1;
            q_a.push_back(t.exp);
            prev    = seg_a;
        end else begin
            value_b = {11'(t.v1), 11'(t.v0)};
            mode_b  = t.mode;
            load_b  = 1'b1;
            q_b.push_back(t.exp);
            prev    = seg_b;
        end
        @(posedge clk);
        #1;
        load_a = 1'b0;
        load_b = 1'b0;
        check({t.name, "_busy"}, t.sel ? busy_b : busy_a, 1);
        seen = 1'b0;
        held = 1'b1;
        for (int k = 1; k <= 60 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (t.sel ? done_b : done_a) begin
                seen = 1'b1;
                check({t.name, "_latency"}, k, lat);
            end else if ((t.sel ? seg_b : seg_a) !== prev) begin
                held = 1'b0;
            end
        end
        if (!seen) check({t.name, "_timeout"}, 0, 1);
        check({t.name, "_seg_held"}, held, 1);
    endtask

    initial begin
        int dones;
        int first;
        int second;

        vecs[0]  = mk("dec_m123_45",   0, 1, -123, 45,
                      LZB ? 48'hFF9992_79A4B0 : 48'hC09992_79A4B0);
        vecs[1]  = mk("dec_m256_7",    0, 1, -256, 7,
                      LZB ? 48'hFFFFF8_249282 : 48'hC0C0F8_249282);
        vecs[2]  = mk("hex_1ab_0ff",   0, 0, 'h1AB, 'h0FF, 48'hC08E8E_F98883);
        vecs[3]  = mk("dec_0_255",     0, 1, 0, 255,
                      LZB ? 48'hA49292_FFFFC0 : 48'hA49292_C0C0C0);
        vecs[4]  = mk("dec_m1_m5",     0, 1, -1, -5,
                      LZB ? 48'h7FFF92_7FFFF9 : 48'h40C092_40C0F9);
        vecs[5]  = mk("hex_1ff_100",   0, 0, -1, 'h100, 48'hF9C0C0_F98E8E);
        vecs[6]  = mk("dec_100_m100",  0, 1, 100, -100, 48'h79C0C0_F9C0C0);
        vecs[7]  = mk("dec_255_m255",  0, 1, 255, -255, 48'h249292_A49292);
        vecs[8]  = mk("dec_10_m10",    0, 1, 10, -10,
                      LZB ? 48'h7FF9C0_FFF9C0 : 48'h40F9C0_C0F9C0);
        vecs[9]  = mk("w11_1000_m1000", 1, 1, 1000, -1000, 48'h3FBFBF_BFBFBF);
        vecs[10] = mk("w11_999_m999",  1, 1, 999, -999, 48'h109090_909090);
        vecs[11] = mk("w11_m1024_1023", 1, 1, -1024, 1023, 48'hBFBFBF_3FBFBF);
        vecs[12] = mk("w11_hex_7ff_400", 1, 0, 'h7FF, 'h400, 48'h99C0C0_F88E8E);
        vecs[13] = mk("w11_5_m7",      1, 1, 5, -7,
                      LZB ? 48'h7FFFF8_FFFF92 : 48'h40C0F8_C0C092);

        reset_n = 1'b0;
        load_a  = 1'b0;  mode_a = 1'b0;  value_a = '0;
        load_b  = 1'b0;  mode_b = 1'b0;  value_b = '0;

        // Reset state.
        #12;
        check("rst_seg_a",  seg_a,  BLANK);
        check("rst_busy_a", busy_a, 0);
        check("rst_done_a", done_a, 0);
        check("rst_seg_b",  seg_b,  BLANK);
        @(posedge clk);
        #1 reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i]);
        end

        // Reset in the middle of SHIFT: immediate blank/idle, no done afterwards.
        @(negedge clk);
        value_a = {9'd50, 9'd200};
        mode_a  = 1'b1;
        load_a  = 1'b1;
        @(posedge clk);
        #1 load_a = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_seg_a",  seg_a,  BLANK);
        check("midrst_busy_a", busy_a, 0);
        check("midrst_done_a", done_a, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done_a) dones++;
        end
        check("midrst_no_done",   dones, 0);
        check("midrst_seg_blank", seg_a, BLANK);

        // First load after reset release is taken on the first rising edge.
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        run_vec(vecs[0]);

        // Load held high through the whole conversion: one done per
        // conversion, and a new one begins only from IDLE after done.
        @(negedge clk);
        value_a = {9'h000, 9'h1AB};
        mode_a  = 1'b0;
        load_a  = 1'b1;
        q_a.push_back(48'hC0C0C0_F98883);
        q_a.push_back(48'hC0C0C0_F98883);
        dones  = 0;
        first  = -1;
        second = -1;
        @(posedge clk);
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (k == LAT_A)     check("hold_idle_at_done", busy_a, 0);
            if (k == LAT_A + 1) check("hold_restart_busy", busy_a, 1);
            if (done_a) begin
                dones++;
                if (dones == 1) first = k;
                else if (dones == 2) second = k;
            end
            if (k == 2 * LAT_A + 1) load_a = 1'b0;
        end
        check("hold_done_count", dones, 2);
        check("hold_first_done", first, LAT_A);
        check("hold_second_done", second, 2 * LAT_A + 1);

        repeat (5) @(posedge clk);
        check("queue_a_drained", q_a.size(), 0);
        check("queue_b_drained", q_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seg7_num_display.md
SEG7_NUM_DISPLAY -- requirements
Module: seg7_num_display

Interface
REQ-001 SHALL provide parameter WIDTH, default 9: bit width of each signed input value.
REQ-002 SHALL provide parameter DIGITS, default 3: seven-segment digits per channel.
REQ-003 SHALL provide parameter CHANNELS, default 2: independent values displayed.
REQ-004 Port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-005 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 Port load, input, 1: conversion request, sampled only in IDLE.
REQ-007 Port mode, input, 1: 0 = hex, 1 = signed decimal; captured with load.
REQ-008 Port value, input, CHANNELS*WIDTH: two's-complement values; channel c occupies value[c*WIDTH +: WIDTH].
REQ-009 Port busy, output, 1: high in every non-IDLE state.
REQ-010 Port done, output, 1: one-cycle pulse when new segments are presented.
REQ-011 Port seg, output, CHANNELS*DIGITS*8: active-low {dp,g,f,e,d,c,b,a}; channel c digit d (d=0 least significant) at seg[(c*DIGITS+d)*8 +: 8].

Function
REQ-012 FSM states SHALL be IDLE, ABS, SHIFT, COMMIT, DONE.
REQ-013 IDLE with load=1: capture value and mode into shadow registers, select channel 0, go to ABS.
REQ-014 ABS (1 cycle): form unsigned WIDTH-bit magnitude and sign bit; -2^(WIDTH-1) SHALL yield magnitude 2^(WIDTH-1); hex mode SHALL pass raw bits with sign 0.
REQ-015 SHIFT (exactly WIDTH cycles): decimal mode performs one double-dabble step per cycle (add 3 to each BCD nibble >= 5, then shift left 1); hex mode shifts raw bits unchanged.
REQ-016 COMMIT (1 cycle): encode the channel's DIGITS digits into a pending segment buffer; go to ABS for next channel, or to DONE after channel CHANNELS-1.
REQ-017 DONE (1 cycle): copy the pending buffer to seg for all channels simultaneously, assert done, return to IDLE.
REQ-018 Latency: done SHALL be high in the cycle beginning CHANNELS*(WIDTH+2)+1 rising edges after the edge sampling load (23 at defaults).
REQ-019 seg SHALL hold its previous value until DONE; no partial updates are visible.
REQ-020 load while busy SHALL be ignored, not queued; load in the DONE cycle SHALL be ignored.
REQ-021 Glyphs: 0-F = C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E (hex, dp off).
REQ-022 Decimal negative: dp of digit DIGITS-1 SHALL be driven low.
REQ-023 Decimal overflow (magnitude > 10^DIGITS-1): all channel digits SHALL show BF (g only), dp per REQ-022.
REQ-024 Hex mode: low DIGITS nibbles of the raw value, zero-extended if WIDTH < 4*DIGITS; dp SHALL be off.

Reset
REQ-025 reset_n low SHALL immediately force IDLE, busy=0, done=0, all seg bits 1 (blank), and clear shadow, BCD and pending registers, including mid-conversion.
REQ-026 The first load after reset_n deassertion SHALL be accepted on the first rising edge.

Configuration
REQ-027 Macro SEG7_LZB_EN defined: in decimal mode, leading zero digits above digit 0 SHALL be blanked (FF, dp still per REQ-022); digit 0 SHALL always be shown; hex and overflow outputs are unaffected.
REQ-028 Macro SEG7_LZB_EN undefined: all digits SHALL be shown, including leading zeros (C0).

Verification
REQ-029 Reset: assert reset_n=0 mid-SHIFT -> seg all FF, busy=0, done=0 in the same cycle; no done follows.
REQ-030 Defaults, LZB on, decimal: ch0=-123, ch1=45 -> done at edge 23; ch0 = 79,A4,B0 (d2..d0); ch1 = FF,99,92.
REQ-031 Defaults, decimal, ch0=-256 (9'h100) -> ch0 = 24,92,82; LZB off, ch1=7 -> C0,C0,F8.
REQ-032 WIDTH=11, DIGITS=3, decimal: value 1000 -> BF,BF,BF with dp off; -1000 -> 3F,BF,BF.
REQ-033 Hex mode, value 9'h1AB -> F9,88,83; a second load held high throughout busy -> exactly one done pulse, and a new conversion starts only after return to IDLE.
